map_addr_latch: RTL and testbench

Parametrised address-latched bank mapper core, successor to the fixed 2-bit PRG / 3-bit CHR address-decoded mapper (map_idx 244 family). A CPU write into a decode window selects the bank from the low address bits; the data bus is ignored. New in this generation:
- configurable bank widths and window bases;
- an optional data-written outer (multicart) bank with a one-shot lock;
- an RMW double-write filter;
- optional bus-conflict masking.

Sits inside a mapper wrapper, which drives `prg_addr`/`chr_addr` high bits from its bank outputs.

---
 rtl/map_addr_latch.sv | 85 ++++++++
 tb/tb_map_addr_latch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/map_addr_latch.sv
// map_addr_latch: address-latched PRG/CHR bank mapper with lockable outer bank and save-state access
module map_addr_latch #(
    parameter int         PRG_W        = 2,
    parameter int         CHR_W        = 3,
    parameter logic [7:0] PRG_BASE     = 8'h65,
    parameter logic [7:0] CHR_BASE     = 8'hA5,
    parameter int         WIN_SZ       = 64,
    parameter int         OUTER_W      = 2,
    parameter bit         RMW_FILTER   = 1'b1,
    parameter bit         BUS_CONFLICT = 1'b0,
    parameter logic [7:0] MAP_IDX      = 8'd244
) (
    input  logic                                     m2,
    input  logic                                     map_rst,
    input  logic                                     cpu_ce,
    input  logic                                     cpu_rw,
    input  logic [14:0]                              cpu_addr,
    input  logic [7:0]                               cpu_dat,
    input  logic [7:0]                               prg_rom_dat,
    input  logic                                     ss_act,
    input  logic                                     ss_we,
    input  logic [7:0]                               ss_addr,
    input  logic [7:0]                               ss_wdat,
    output logic [7:0]                               ss_rdat,
    output logic [PRG_W-1:0]                         prg_bank,
    output logic [CHR_W-1:0]                         chr_bank,
    output logic [(OUTER_W > 0 ? OUTER_W : 1)-1:0]   outer_bank,
    output logic                                     locked,
    output logic                                     wr_ack
);
    localparam int OW = OUTER_W > 0 ? OUTER_W : 1;

    logic       prev_wr, wr, acc, page0, prg_hit, chr_hit, out_hit, ss_wr;
    logic [7:0] lo, d;

    // Write decode: filtered strobe, window hits and the outer data value
    always_comb begin
        wr      = !cpu_ce && !cpu_rw;
        acc     = wr && !(RMW_FILTER && prev_wr) && !ss_act;
        lo      = cpu_addr[7:0];
        page0   = cpu_addr[14:8] == 7'd0;
        prg_hit = acc && page0 && int'(lo) >= int'(PRG_BASE) && int'(lo) < int'(PRG_BASE) + WIN_SZ;
        chr_hit = acc && page0 && int'(lo) >= int'(CHR_BASE) && int'(lo) < int'(CHR_BASE) + WIN_SZ;
        out_hit = acc && cpu_addr[14] && !locked && OUTER_W > 0;
        d       = cpu_dat & (BUS_CONFLICT ? prg_rom_dat : 8'hFF);
        ss_wr   = ss_act && ss_we;
    end

    // Bank, lock and handshake state; save-state writes override the CPU path
    always_ff @(negedge m2 or posedge map_rst) begin
        if (map_rst) begin
            prg_bank   <= '0;
            chr_bank   <= '0;
            outer_bank <= '0;
            locked     <= 1'b0;
            prev_wr    <= 1'b0;
            wr_ack     <= 1'b0;
        end else begin
            prev_wr <= wr && !ss_act;
            wr_ack  <= prg_hit || chr_hit || out_hit;
            if (ss_wr) begin
                if (ss_addr == 8'd0) prg_bank <= PRG_W'(ss_wdat);
                if (ss_addr == 8'd1) chr_bank <= CHR_W'(ss_wdat);
                if (ss_addr == 8'd2 && OUTER_W > 0) outer_bank <= OW'(ss_wdat);
                if (ss_addr == 8'd3) locked <= ss_wdat[0];
            end else begin
                if (prg_hit) prg_bank <= PRG_W'(lo - PRG_BASE);
                if (chr_hit) chr_bank <= CHR_W'(lo - CHR_BASE);
                if (out_hit) begin
                    outer_bank <= OW'(d);
                    locked     <= d[7];
                end
            end
        end
    end

    // Save-state read mux, zero-extended register views
    always_comb begin
        ss_rdat = ss_addr == 8'd0   ? 8'(prg_bank)   :
                  ss_addr == 8'd1   ? 8'(chr_bank)   :
                  ss_addr == 8'd2   ? 8'(outer_bank) :
                  ss_addr == 8'd3   ? {7'b0, locked} :
                  ss_addr == 8'd127 ? MAP_IDX        : 8'hFF;
    end
endmodule

// File: tb/tb_map_addr_latch.sv
// tb_map_addr_latch: directed and random checks of two mapper instances (plain and bus-conflict)
module tb_map_addr_latch;
    logic        m2 = 1'b0, map_rst = 1'b1, cpu_ce = 1'b1, cpu_rw = 1'b1;
    logic [14:0] cpu_addr = '0;
    logic [7:0]  cpu_dat = '0, prg_rom_dat = 8'hFF;
    logic        ss_act = 1'b0, ss_we = 1'b0;
    logic [7:0]  ss_addr = '0, ss_wdat = '0;
    logic [7:0]  ss_rdat, bc_rdat;
    logic [1:0]  prg_bank, outer_bank, bc_prg, bc_out;
    logic [2:0]  chr_bank, bc_chr;
    logic        locked, wr_ack, bc_lock, bc_ack;

    int n_vec = 0, n_err = 0;
    int m_prg[2], m_chr[2], m_out[2], m_lock[2], m_ack[2];
    bit m_prev;

    map_addr_latch dut (
        .m2(m2), .map_rst(map_rst), .cpu_ce(cpu_ce), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_dat(cpu_dat), .prg_rom_dat(prg_rom_dat), .ss_act(ss_act), .ss_we(ss_we),
        .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat), .prg_bank(prg_bank),
        .chr_bank(chr_bank), .outer_bank(outer_bank), .locked(locked), .wr_ack(wr_ack)
    );

    map_addr_latch #(.BUS_CONFLICT(1'b1)) dut_bc (
        .m2(m2), .map_rst(map_rst), .cpu_ce(cpu_ce), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_dat(cpu_dat), .prg_rom_dat(prg_rom_dat), .ss_act(ss_act), .ss_we(ss_we),
        .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(bc_rdat), .prg_bank(bc_prg),
        .chr_bank(bc_chr), .outer_bank(bc_out), .locked(bc_lock), .wr_ack(bc_ack)
    );

    always #5 m2 = ~m2;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_prg[k] = 0; m_chr[k] = 0; m_out[k] = 0; m_lock[k] = 0; m_ack[k] = 0;
        end
        m_prev = 1'b0;
    endtask

    // Behaviour of one falling edge, from the mapper rules in plain arithmetic
    task automatic model_step();
        bit w = !cpu_ce && !cpu_rw;
        int a = int'(cpu_addr);
        int dd;
        for (int k = 0; k < 2; k++) begin
            m_ack[k] = 0;
            if (ss_act) begin
                if (ss_we) begin
                    if (ss_addr == 0) m_prg[k] = int'(ss_wdat) % 4;
                    if (ss_addr == 1) m_chr[k] = int'(ss_wdat) % 8;
                    if (ss_addr == 2) m_out[k] = int'(ss_wdat) % 4;
                    if (ss_addr == 3) m_lock[k] = int'(ss_wdat) % 2;
                end
            end else if (w && !m_prev) begin
                if (a < 256 && a >= 'h65 && a < 'h65 + 64) begin
                    m_prg[k] = (a - 'h65) % 4; m_ack[k] = 1;
                end
                if (a < 256 && a >= 'hA5 && a < 'hA5 + 64) begin
                    m_chr[k] = (a - 'hA5) % 8; m_ack[k] = 1;
                end
                if (a >= 'h4000 && m_lock[k] == 0) begin
                    dd = k == 1 ? int'(cpu_dat & prg_rom_dat) : int'(cpu_dat);
                    m_out[k] = dd % 4; m_lock[k] = dd >= 128 ? 1 : 0; m_ack[k] = 1;
                end
            end
        end
        m_prev = w && !ss_act;
    endtask

    function automatic logic [7:0] exp_rdat(input int k);
        case (ss_addr)
            8'd0:    return 8'(m_prg[k]);
            8'd1:    return 8'(m_chr[k]);
            8'd2:    return 8'(m_out[k]);
            8'd3:    return 8'(m_lock[k]);
            8'd127:  return 8'd244;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check_all();
        chk("prg", 8'(prg_bank), 8'(m_prg[0]));
        chk("chr", 8'(chr_bank), 8'(m_chr[0]));
        chk("outer", 8'(outer_bank), 8'(m_out[0]));
        chk("locked", 8'(locked), 8'(m_lock[0]));
        chk("wr_ack", 8'(wr_ack), 8'(m_ack[0]));
        chk("ss_rdat", ss_rdat, exp_rdat(0));
        chk("bc_prg", 8'(bc_prg), 8'(m_prg[1]));
        chk("bc_chr", 8'(bc_chr), 8'(m_chr[1]));
        chk("bc_outer", 8'(bc_out), 8'(m_out[1]));
        chk("bc_locked", 8'(bc_lock), 8'(m_lock[1]));
        chk("bc_wr_ack", 8'(bc_ack), 8'(m_ack[1]));
        chk("bc_ss_rdat", bc_rdat, exp_rdat(1));
    endtask

    task automatic cyc(input logic ce, input logic rw, input logic [14:0] a, input logic [7:0] d,
                       input logic [7:0] rom, input logic sa, input logic swe,
                       input logic [7:0] sad, input logic [7:0] swd);
        cpu_ce = ce; cpu_rw = rw; cpu_addr = a; cpu_dat = d; prg_rom_dat = rom;
        ss_act = sa; ss_we = swe; ss_addr = sad; ss_wdat = swd;
        @(negedge m2);
        model_step();
        @(posedge m2);
        check_all();
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d, input logic [7:0] rom);
        cyc(1'b0, 1'b0, a, d, rom, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b1, 15'd0, 8'd0, 8'hFF, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic ssw(input logic [7:0] sad, input logic [7:0] swd);
        cyc(1'b1, 1'b1, 15'd0, 8'd0, 8'hFF, 1'b1, 1'b1, sad, swd);
    endtask

    task automatic ssr(input logic [7:0] sad);
        cyc(1'b1, 1'b1, 15'd0, 8'd0, 8'hFF, 1'b1, 1'b0, sad, 8'd0);
    endtask

    // Asynchronous reset pulse placed between edges, checked before the next falling edge
    task automatic rst_pulse();
        #2 map_rst = 1'b1;
        #1 model_reset();
        check_all();
        #1 map_rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge m2);
        check_all();
        chk("rst_prg", 8'(prg_bank), 8'd0);
        map_rst = 1'b0;
        idle();
        wr(15'h065, 8'h00, 8'hFF);
        chk("dir_ack_065", 8'(wr_ack), 8'd1);
        idle();
        chk("dir_ack_fall", 8'(wr_ack), 8'd0);
        wr(15'h0A4, 8'h00, 8'hFF);
        chk("dir_prg_0a4", 8'(prg_bank), 8'd3);
        idle();
        wr(15'h0E4, 8'h00, 8'hFF);
        chk("dir_chr_0e4", 8'(chr_bank), 8'd7);
        idle();
        wr(15'h064, 8'h00, 8'hFF);
        chk("dir_ack_064", 8'(wr_ack), 8'd0);
        idle();
        wr(15'h0E5, 8'h00, 8'hFF);
        chk("dir_chr_0e5", 8'(chr_bank), 8'd7);
        idle();
        wr(15'h066, 8'h00, 8'hFF);
        wr(15'h067, 8'h00, 8'hFF);
        chk("dir_rmw_prg", 8'(prg_bank), 8'd1);
        chk("dir_rmw_ack", 8'(wr_ack), 8'd0);
        wr(15'h065, 8'h00, 8'hFF);
        chk("dir_rmw_third", 8'(prg_bank), 8'd1);
        idle();
        wr(15'h066, 8'h00, 8'hFF);
        cyc(1'b0, 1'b1, 15'h000, 8'h00, 8'hFF, 1'b0, 1'b0, 8'd0, 8'd0);
        wr(15'h067, 8'h00, 8'hFF);
        chk("dir_rd_prg", 8'(prg_bank), 8'd2);
        chk("dir_rd_ack", 8'(wr_ack), 8'd1);
        idle();
        wr(15'h4000, 8'h02, 8'hFF);
        chk("dir_out_02", 8'(outer_bank), 8'd2);
        idle();
        wr(15'h4000, 8'h83, 8'h01);
        chk("dir_out_83", 8'(outer_bank), 8'd3);
        chk("dir_lock_83", 8'(locked), 8'd1);
        chk("dir_bc_out", 8'(bc_out), 8'd1);
        chk("dir_bc_lock", 8'(bc_lock), 8'd0);
        idle();
        wr(15'h4000, 8'h01, 8'hFF);
        chk("dir_out_locked", 8'(outer_bank), 8'd3);
        chk("dir_ack_locked", 8'(wr_ack), 8'd0);
        idle();
        rst_pulse();
        chk("dir_rst_out", 8'(outer_bank), 8'd0);
        ssw(8'd0, 8'd2);
        ssw(8'd1, 8'd5);
        ssw(8'd2, 8'd1);
        ssw(8'd3, 8'd1);
        ssr(8'd0);
        chk("dir_ss_r0", ss_rdat, 8'd2);
        ssr(8'd1);
        chk("dir_ss_r1", ss_rdat, 8'd5);
        ssr(8'd2);
        ssr(8'd3);
        chk("dir_ss_r3", ss_rdat, 8'd1);
        ssr(8'd127);
        chk("dir_ss_idx", ss_rdat, 8'd244);
        ssr(8'd9);
        chk("dir_ss_ff", ss_rdat, 8'hFF);
        cyc(1'b0, 1'b0, 15'h065, 8'h00, 8'hFF, 1'b1, 1'b0, 8'd0, 8'd0);
        chk("dir_ss_frozen", 8'(prg_bank), 8'd2);
        idle();
        wr(15'h065, 8'h00, 8'hFF);
        cpu_ce = 1'b0; cpu_rw = 1'b0; cpu_addr = 15'h0A4;
        rst_pulse();
        wr(15'h0A4, 8'h00, 8'hFF);
        chk("dir_post_rst", 8'(prg_bank), 8'd3);
        for (int i = 0; i < 600; i++) begin
            int r, pick;
            logic [14:0] a;
            logic [7:0] sa;
            r = int'($urandom_range(0, 99));
            pick = int'($urandom_range(0, 3));
            a = pick == 0 ? 15'($urandom_range(0, 255)) :
                pick == 1 ? 15'('h4000 | $urandom_range(0, 255)) : 15'($urandom);
            sa = $urandom_range(0, 4) == 4 ? 8'd127 : 8'($urandom_range(0, 5));
            if (r < 2) rst_pulse();
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, a, 8'($urandom),
                8'($urandom), r >= 2 && r < 12, $urandom_range(0, 1) == 1, sa, 8'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
